// File: rtl/sm_pkg.sv
// Shared sign-magnitude format and FSM state encoding for the accumulator slice.
package sm_pkg;
  localparam int SM_W     = 16;
  localparam int SIGN_BIT = 15;
  localparam int MAG_W    = 15;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_t;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder: aligns signs, adds or subtracts magnitudes,
// and folds any zero-magnitude result to +0.
module sm_add_core
  import sm_pkg::*;
(
  input  sm_t  a,
  input  sm_t  b,
  output sm_t  sum,
  output logic carry
);
  logic [MAG_W:0] wide;

  always_comb begin
    wide  = '0;
    sum   = '0;
    carry = 1'b0;
    if (a.sign == b.sign) begin
      wide     = {1'b0, a.mag} + {1'b0, b.mag};
      sum.mag  = wide[MAG_W-1:0];
      sum.sign = a.sign;
      carry    = wide[MAG_W];
    end else if (a.mag >= b.mag) begin
      sum.mag  = a.mag - b.mag;
      sum.sign = a.sign;
    end else begin
      sum.mag  = b.mag - a.mag;
      sum.sign = b.sign;
    end
    // Wrapped or cancelled results must never come out as -0.
    if (sum.mag == '0) sum.sign = 1'b0;
  end
endmodule

// File: rtl/sm_accum_unit.sv
// Sequential sign-magnitude accumulator: takes len operands over valid/ready,
// then holds the sum and flags in DONE until the consumer accepts them.
module sm_accum_unit
  import sm_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             neg,
  output logic             busy
);
  state_t           state_q, state_d;
  sm_t              acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  sm_t  op;
  sm_t  sum;
  logic carry;
  logic unused_hi;

  assign unused_hi = ^in_data[N-1:SM_W];
  assign op.sign   = in_data[SIGN_BIT] ^ in_sub;
  assign op.mag    = in_data[MAG_W-1:0];

  sm_add_core u_core (
    .a     (acc_q),
    .b     (op),
    .sum   (sum),
    .carry (carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = len;
          acc_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b1;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d  = sum;
          cout_d = carry;
          ovf_d  = ovf_q | carry;
          zero_d = (sum.mag == '0);
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // A start arriving with the handshake is dropped: we only leave for IDLE here.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = {{(N-SM_W){1'b0}}, acc_q};
  assign neg       = acc_q.sign;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_sm_accum_unit.sv
// Scoreboard bench for sm_accum_unit: expected results are computed from an
// integer reference model as operands are driven, then popped when out_valid rises.
module tb_sm_accum_unit;
  localparam int N     = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_data = '0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_data;
  logic             cout, zero, overflow, neg, busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] exp_q[$];
  logic [35:0] obs;
  logic [35:0] exp_v;

  assign obs = {out_data, cout, zero, overflow, neg};

  sm_accum_unit #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cout(cout), .zero(zero), .overflow(overflow), .neg(neg), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: returns {carry, sign, mag[14:0]} using signed integer arithmetic.
  function automatic logic [16:0] model_step(input logic [15:0] acc, input logic [15:0] op,
                                             input logic sub);
    int   va, vb, m;
    logic sa, sb, s, c;
    sa = acc[15];
    sb = op[15] ^ sub;
    c  = 1'b0;
    if (sa == sb) begin
      m = int'(acc[14:0]) + int'(op[14:0]);
      c = (m >= 32768);
      m = m % 32768;
      s = sa;
    end else begin
      va = sa ? -int'(acc[14:0]) : int'(acc[14:0]);
      vb = sb ? -int'(op[14:0])  : int'(op[14:0]);
      m  = va + vb;
      s  = (m < 0);
      if (m < 0) m = -m;
    end
    if (m == 0) s = 1'b0;
    return {c, s, m[14:0]};
  endfunction

  // Drives start plus n beats; leaves the bench 1ns after the last accepting edge.
  task automatic send_seq(input int n, input logic [15:0] d[4], input logic [3:0] s);
    logic [15:0] acc;
    logic        cy, ovf;
    logic [16:0] r;
    acc = '0; cy = 1'b0; ovf = 1'b0;
    start = 1'b1;
    len   = n[CNT_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = {16'($urandom), d[i]};
      in_sub   = s[i];
      r   = model_step(acc, d[i], s[i]);
      acc = r[15:0];
      cy  = r[16];
      ovf = ovf | r[16];
      begin : wait_rdy
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        if (!in_ready) begin
          n_cmp++; n_bad++;
          $display("FAIL in_ready_timeout beat %0d: in_ready=%b required 1", i, in_ready);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sub   = 1'b0;
    exp_q.push_back({16'h0, acc, cy, (acc[14:0] == 15'h0), ovf, acc[15]});
  endtask

  task automatic wait_out(output bit ok);
    int k;
    k = 0;
    while (!out_valid && k < 30) begin @(negedge clk); k++; end
    ok = out_valid;
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_one(input string name, input int n, input logic [15:0] d[4],
                         input logic [3:0] s);
    bit ok;
    send_seq(n, d, s);
    wait_out(ok);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (!ok || obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got vld=%b %h required %h", name, out_valid, obs, exp_v);
    end
    take_out();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({in_ready, out_valid, obs, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b %h busy=%b required all 0",
               in_ready, out_valid, obs, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_seq(3, '{16'h0005, 16'h0007, 16'h8003, 16'h0000}, 4'b0000);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_latency: out_valid=%b one cycle after last beat, required 1", out_valid);
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v || obs !== {32'h0000_0009, 4'b0000}) begin
      n_bad++;
      $display("FAIL basic_sum: got %h required %h", obs, exp_v);
    end
    take_out();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_release: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_signs();
    run_one("sub_neg", 2, '{16'h0004, 16'h000A, 16'h0, 16'h0}, 4'b0010);
    run_one("cancel_no_negzero", 2, '{16'h1234, 16'h9234, 16'h0, 16'h0}, 4'b0000);
    run_one("mixed_four", 4, '{16'h8100, 16'h0050, 16'h8020, 16'h0300}, 4'b0100);
  endtask

  task automatic test_overflow();
    run_one("overflow_wrap", 2, '{16'h7FFF, 16'h0001, 16'h0, 16'h0}, 4'b0000);
    n_cmp++;
    if ({out_data, cout, zero, overflow} !== {32'h0, 3'b111}) begin
      n_bad++;
      $display("FAIL overflow_flags: got %h cout=%b zero=%b ovf=%b required 0 1 1 1",
               out_data, cout, zero, overflow);
    end
    run_one("overflow_cleared", 1, '{16'h0002, 16'h0, 16'h0, 16'h0}, 4'b0000);
  endtask

  task automatic test_backpressure();
    bit ok;
    send_seq(2, '{16'h8010, 16'h0003, 16'h0, 16'h0}, 4'b0000);
    wait_out(ok);
    exp_v = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      len   = 8'd0;
      @(negedge clk);
      n_cmp++;
      if (!ok || out_valid !== 1'b1 || obs !== exp_v) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: vld=%b %h required 1 %h", c, out_valid, obs, exp_v);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL start_at_handshake: busy=%b vld=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_len_zero();
    send_seq(0, '{16'h0, 16'h0, 16'h0, 16'h0}, 4'b0000);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || obs !== exp_v || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL len_zero: vld=%b %h required 1 %h", out_valid, obs, exp_v);
    end
    take_out();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    len   = 8'd3;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0000_0005;
    @(posedge clk); #1;
    in_data  = 32'h0000_0006;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, obs, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: rdy=%b vld=%b %h busy=%b required all 0",
               in_ready, out_valid, obs, busy);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    run_one("after_reset", 1, '{16'h0003, 16'h0, 16'h0, 16'h0}, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
